// File: rtl/gsim_band_mult.sv
// rtl/gsim_band_mult.sv - banded-matrix forward model b = A*x for the GSIM solver
// Buffers N Q16.16 elements, then streams N rounded and saturated 16-bit row sums.
module gsim_band_mult #(
  parameter int N    = 16,
  parameter int FRAC = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_en,
  input  logic [31:0] x_in,
  output logic        busy,
  output logic        out_valid,
  output logic [15:0] b_out
);

  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  typedef enum logic [1:0] {IDLE, LOAD, CALC} state_t;

  state_t            state, state_d;
  logic [AW-1:0]     idx, idx_d, row, row_d;
  logic              wr_en, out_valid_d;
  logic [15:0]       b_out_d, sat;
  logic [31:0]       buffer [N];
  logic signed [38:0] acc, rnd, t;

  // Band coefficients as shift-add: 20 = 16+4, 13 = 8+4+1, 6 = 4+2.
  function automatic logic signed [38:0] weigh(input logic [31:0] x, input int d);
    logic signed [38:0] v;
    v = 39'($signed(x));
    case (d)
      0:       return (v <<< 4) + (v <<< 2);
      1, -1:   return -((v <<< 3) + (v <<< 2) + v);
      2, -2:   return (v <<< 2) + (v <<< 1);
      3, -3:   return -v;
      default: return '0;
    endcase
  endfunction

  always_comb begin
    acc = '0;
    for (int d = -3; d <= 3; d++) begin
      if ((int'(row) + d) >= 0 && (int'(row) + d) < N)
        acc = acc + weigh(buffer[AW'(int'(row) + d)], d);
    end
    rnd = acc + (39'sd1 <<< (FRAC - 1));
    t   = rnd >>> FRAC;
    if (t > 39'sd32767)
      sat = 16'h7fff;
    else if (t < -39'sd32768)
      sat = 16'h8000;
    else
      sat = t[15:0];
  end

  always_comb begin
    state_d     = state;
    idx_d       = idx;
    row_d       = row;
    wr_en       = 1'b0;
    out_valid_d = 1'b0;
    b_out_d     = b_out;
    case (state)
      IDLE: begin
        if (in_en) begin
          wr_en   = 1'b1;
          idx_d   = AW'(1);
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (in_en) begin
          wr_en = 1'b1;
          if (idx == LAST) begin
            idx_d   = '0;
            row_d   = '0;
            state_d = CALC;
          end else begin
            idx_d = idx + AW'(1);
          end
        end
      end
      CALC: begin
        out_valid_d = 1'b1;
        b_out_d     = sat;
        if (row == LAST) begin
          row_d   = '0;
          idx_d   = '0;
          state_d = IDLE;
        end else begin
          row_d = row + AW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      idx       <= '0;
      row       <= '0;
      out_valid <= 1'b0;
      b_out     <= '0;
    end else begin
      state     <= state_d;
      idx       <= idx_d;
      row       <= row_d;
      out_valid <= out_valid_d;
      b_out     <= b_out_d;
    end
  end

  // Buffer contents are don't-care after reset, so no reset term here.
  always_ff @(posedge clk) begin
    if (wr_en)
      buffer[idx] <= x_in;
  end

  assign busy = (state == CALC);

endmodule

// File: tb/tb_gsim_band_mult.sv
// tb/tb_gsim_band_mult.sv - scoreboard bench for gsim_band_mult
// Expected rows are queued when a vector is driven and popped as out_valid beats arrive.
module tb_gsim_band_mult;
  localparam int N    = 16;
  localparam int FRAC = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_en = 1'b0;
  logic [31:0] x_in = '0;
  logic        busy, out_valid;
  logic [15:0] b_out;

  gsim_band_mult #(.N(N), .FRAC(FRAC)) dut (
    .clk(clk), .reset(reset), .in_en(in_en), .x_in(x_in),
    .busy(busy), .out_valid(out_valid), .b_out(b_out)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  int vcount = 0;
  int exp_q[$];
  int bin_q[$];
  bit tol_mode = 1'b0;
  int xv[N];

  task automatic chk(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int coef(input int d);
    case (d)
      0:       return 20;
      1, -1:   return -13;
      2, -2:   return 6;
      3, -3:   return -1;
      default: return 0;
    endcase
  endfunction

  function automatic int model_row(input int r);
    longint acc, tq;
    acc = 0;
    for (int j = 0; j < N; j++)
      if (j - r <= 3 && r - j <= 3) acc += longint'(coef(j - r)) * longint'(xv[j]);
    tq = (acc + 64'sd32768) / 65536;
    if ((acc + 64'sd32768) < 0 && ((acc + 64'sd32768) % 65536) != 0) tq = tq - 1;
    if (tq > 32767) tq = 32767;
    if (tq < -32768) tq = -32768;
    return int'(tq);
  endfunction

  always @(negedge clk) begin
    int e, bi, d;
    if (reset && out_valid) begin
      vcount++;
      if (exp_q.size() == 0) begin
        chk("spurious_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("b_out", longint'($signed(b_out)), e);
        if (tol_mode && bin_q.size() > 0) begin
          bi = bin_q.pop_front();
          d  = int'($signed(b_out)) - bi;
          chk("gsim_tol", (d <= 1 && d >= -1), 1);
        end
      end
    end
  end

  task automatic drive_elems(input int count, input bit gaps);
    for (int k = 0; k < count; k++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 2);
        for (int s = 0; s < g; s++) begin
          in_en = 1'b0;
          x_in  = $urandom;
          @(posedge clk); #1;
        end
      end
      in_en = 1'b1;
      x_in  = xv[k];
      @(posedge clk); #1;
    end
  endtask

  task automatic send_vec(input bit gaps, input bit junk);
    int v0, last;
    v0 = vcount;
    for (int r = 0; r < N; r++) exp_q.push_back(model_row(r));
    last = exp_q[N-1];
    drive_elems(N, gaps);
    in_en = junk;
    x_in  = $urandom;
    @(negedge clk);
    chk("latency_pre", out_valid, 0);
    @(posedge clk); #1;
    x_in = $urandom;
    @(negedge clk);
    chk("latency_first", out_valid, 1);
    chk("busy_calc", busy, 1);
    for (int i = 2; i <= N; i++) begin
      @(posedge clk); #1;
      x_in = $urandom;
    end
    in_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("valid_drop", out_valid, 0);
    chk("valid_count", vcount - v0, N);
    chk("queue_empty", exp_q.size(), 0);
    chk("busy_idle", busy, 0);
    chk("b_out_hold", longint'($signed(b_out)), last);
    @(posedge clk); #1;
  endtask

  task automatic set_all(input int v);
    for (int i = 0; i < N; i++) xv[i] = v;
  endtask

  task automatic gsim_vec();
    real a[N][N];
    real bb[N];
    real xr[N];
    real f, s;
    int  bin[N];
    for (int i = 0; i < N; i++) begin
      bin[i] = int'($urandom_range(0, 200)) - 100;
      bb[i]  = real'(bin[i]);
      for (int j = 0; j < N; j++) a[i][j] = real'(coef(j - i));
    end
    for (int k = 0; k < N; k++)
      for (int i = k + 1; i < N; i++) begin
        f = a[i][k] / a[k][k];
        for (int j = k; j < N; j++) a[i][j] = a[i][j] - f * a[k][j];
        bb[i] = bb[i] - f * bb[k];
      end
    for (int i = N - 1; i >= 0; i--) begin
      s = bb[i];
      for (int j = i + 1; j < N; j++) s = s - a[i][j] * xr[j];
      xr[i] = s / a[i][i];
    end
    for (int i = 0; i < N; i++) begin
      xv[i] = $rtoi(xr[i] * 65536.0 + ((xr[i] >= 0.0) ? 0.5 : -0.5));
      bin_q.push_back(bin[i]);
    end
    tol_mode = 1'b1;
    send_vec(1'b1, 1'b0);
    tol_mode = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_b_out", b_out, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    set_all(0);
    send_vec(1'b0, 1'b0);

    set_all(0); xv[0] = 32'h0001_0000;
    send_vec(1'b0, 1'b0);

    set_all(32'h0001_0000);
    send_vec(1'b1, 1'b0);

    set_all(0); xv[0] = 32'h0000_8000;
    send_vec(1'b0, 1'b0);

    set_all(0); xv[0] = 32'h7FFF_0000;
    send_vec(1'b0, 1'b1);

    for (int i = 0; i < N; i++) xv[i] = $urandom;
    drive_elems(8, 1'b1);
    in_en = 1'b0;
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    chk("abort_b_out", b_out, 0);
    chk("abort_busy", busy, 0);
    chk("abort_valid", out_valid, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    set_all(32'h0001_0000);
    send_vec(1'b1, 1'b0);

    gsim_vec();

    repeat (3) @(posedge clk);
    chk("final_queue", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gsim_band_mult.md
Name: gsim_band_mult

Overview:
- Forward model of the GSIM solver: takes the 16-element solution vector x in the format GSIM emits (32-bit signed Q16.16, one element per cycle) and computes b = A·x.
- A is the fixed symmetric banded matrix used by GSIM: diagonal 20, off-diagonals ±1 = -13, ±2 = 6, ±3 = -1, truncated at the matrix edges.
- Each b element is emitted as a 16-bit signed integer in the same stream format GSIM consumes.
- Used for closed-loop checking (GSIM x_out → gsim_band_mult → compare with original b_in) and as a stimulus generator for GSIM.

Parameters:
- N, 16, vector length (legal range 4..64); buffer depth and row count.
- FRAC, 16, fractional bits of x_in; b_out = round(acc / 2^FRAC).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_en  input  1  x_in valid this cycle.
- x_in  input  32  signed Q16.16 element x[k], k in arrival order 0..N-1.
- busy  output  1  high in CALC state; in_en is ignored while high.
- out_valid  output  1  b_out valid this cycle.
- b_out  output  16  signed integer b[r], r in order 0..N-1.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, write index=0, row index=0, out_valid=0, b_out=0, busy=0. Buffer contents are don't-care.
- States and transitions:
  - IDLE: on in_en=1, store x_in at buffer[0], index=1, go to LOAD.
  - LOAD: each in_en=1 cycle stores x_in at buffer[index] and increments index. Cycles with in_en=0 are stalls: hold state, no store. The edge that stores element N-1 moves to CALC with r=0.
  - CALC: busy=1. Each cycle, row r is computed combinationally and registered into b_out with out_valid=1 on that edge; r then increments. After row N-1 is registered, go to IDLE with index=0.
  - Result: out_valid is high for exactly N consecutive cycles. It first rises on the edge after the one that accepted x[N-1] (latency 1 cycle).
- Row sum: acc = Σ c(j-r)·x[j] over |j-r|≤3 and 0≤j≤N-1, with c(0)=20, c(±1)=-13, c(±2)=6, c(±3)=-1. Out-of-range terms contribute 0.
  - Coefficients are implemented as shift-add; no generic multipliers.
- Widths: acc is signed, 39 bits, to cover 32 bits plus headroom for Σ|c|=60. No intermediate overflow is permitted.
- Output conversion: t = (acc + 2^(FRAC-1)) >>> FRAC, an arithmetic shift (round half toward +inf). b_out = saturate(t) to [-32768, 32767].
- in_en=1 while busy: data is dropped, state is unaffected, and no error is flagged.
- in_en=1 on the same edge CALC returns to IDLE: that sample is not captured. Capture resumes on the following edge.
- out_valid is registered. b_out holds its last value when out_valid=0.
- Reset asserted mid-LOAD or mid-CALC: immediate abort to reset values; no partial output completes.

Test Plan:
- x all 0x00000000 -> 16 outputs, all 0; out_valid high exactly 16 cycles, rising 1 cycle after the 16th in_en.
- x[0]=0x00010000, rest 0 -> b = 20, -13, 6, -1, then 0 ×12.
- x all 0x00010000 -> b = 12, -1, 5, 4 ×10, 5, -1, 12.
- x[0]=0x00008000, rest 0 -> b = 10, -6, 3, 0, 0… (checks round-half-up on ±0.5 cases).
- x[0]=0x7FFF0000, rest 0 -> b = 32767, -32768, 32767, -32767, 0… (saturation both signs). In the same run, drive in_en=1 during CALC with junk -> output unchanged.
- Feed 8 elements with in_en gaps, pulse reset low for 1 cycle, then a full vector of 1.0 -> b identical to the all-ones case. Also feed back a GSIM x_out stream and check |b_out - b_in| ≤ 1 per element.
